// File: rtl/pic_nest.sv
// Nested-priority interrupt controller: edge-latched requests, mask, in-service ceiling, EOI.
// Optional level-sensitive channels via the PIC_LEVEL_MODE_EN macro (MODE register at offset 2N+4).
module pic_nest #(
    parameter logic [7:0]  PIC_ADDRESS = 8'h00,
    parameter int unsigned NUM_IRQ     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         din,
    input  logic [7:0]         address,
    input  logic               w_en,
    input  logic               r_en,
    output logic [7:0]         dout,
    output logic               interrupt,
    output logic [15:0]        intVect,
    input  logic               intAck,
    input  logic [NUM_IRQ-1:0] irq
);

    localparam int unsigned IW = $clog2(NUM_IRQ + 1);
    localparam logic [7:0] OFF_EN   = 8'(2 * NUM_IRQ);
    localparam logic [7:0] OFF_PEND = 8'(2 * NUM_IRQ + 1);
    localparam logic [7:0] OFF_INS  = 8'(2 * NUM_IRQ + 2);
    localparam logic [7:0] OFF_EOI  = 8'(2 * NUM_IRQ + 3);
`ifdef PIC_LEVEL_MODE_EN
    localparam logic [7:0] OFF_MODE = 8'(2 * NUM_IRQ + 4);
`endif

    logic [7:0]         vect_l_q [NUM_IRQ];
    logic [7:0]         vect_h_q [NUM_IRQ];
    logic [NUM_IRQ-1:0] en_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] ins_q, ins_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [IW-1:0]      cur_q;
    logic               int_q;
    logic [15:0]        vect_q;
    logic [7:0]         dout_q;
`ifdef PIC_LEVEL_MODE_EN
    logic [NUM_IRQ-1:0] mode_q;
`endif

    logic [8:0]         diff;
    logic               in_win;
    logic [7:0]         off;
    logic               wr_hit;
    logic               ack;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [NUM_IRQ-1:0] eoi_mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ins_eff;
    logic               win_found;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      ceil_idx;
    logic               ceil_found;
    logic               eoi_found;
    logic               req;
    logic [15:0]        win_vec;
    logic [7:0]         rdata;

    // Below-base addresses borrow into bit 8 and fall outside the window.
    assign diff   = {1'b0, address} - {1'b0, PIC_ADDRESS};
    assign in_win = ~diff[8];
    assign off    = diff[7:0];
    assign wr_hit = w_en & in_win;

    assign ack      = intAck & int_q;
    assign rise     = irq & ~irq_prev_q;
    assign eligible = pend_q & en_q;

    always_comb begin
        ack_mask = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            ack_mask[i] = ack && (cur_q == IW'(i));
        end
    end

    always_comb begin
        eoi_mask  = '0;
        eoi_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!eoi_found && ins_q[i]) begin
                eoi_mask[i] = 1'b1;
                eoi_found   = 1'b1;
            end
        end
    end

    // The channel being acked counts as in service already, so it drops on the ack edge.
    assign ins_eff = ins_q | ack_mask;

    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        ceil_found = 1'b0;
        ceil_idx   = IW'(NUM_IRQ);
        win_vec    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!win_found && eligible[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
                win_vec   = {vect_h_q[i], vect_l_q[i]};
            end
            if (!ceil_found && ins_eff[i]) begin
                ceil_found = 1'b1;
                ceil_idx   = IW'(i);
            end
        end
    end

    assign req = win_found && (win_idx < ceil_idx);

    // Clears apply before the new edge so a coincident edge keeps the request pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_hit && off == OFF_PEND) begin
            pend_d = pend_d & ~din[NUM_IRQ-1:0];
        end
        pend_d = (pend_d & ~ack_mask) | rise;
`ifdef PIC_LEVEL_MODE_EN
        pend_d = (pend_d & ~mode_q) | (irq & mode_q);
`endif
    end

    always_comb begin
        ins_d = ins_q;
        if (wr_hit && off == OFF_EOI) begin
            ins_d = ins_d & ~eoi_mask;
        end
        ins_d = ins_d | ack_mask;
    end

    always_comb begin
        rdata = '0;
        if (in_win) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (off == 8'(2 * i))     rdata = vect_l_q[i];
                if (off == 8'(2 * i + 1)) rdata = vect_h_q[i];
            end
            if (off == OFF_EN)   rdata[NUM_IRQ-1:0] = en_q;
            if (off == OFF_PEND) rdata[NUM_IRQ-1:0] = pend_q;
            if (off == OFF_INS)  rdata[NUM_IRQ-1:0] = ins_q;
`ifdef PIC_LEVEL_MODE_EN
            if (off == OFF_MODE) rdata[NUM_IRQ-1:0] = mode_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                vect_l_q[i] <= '0;
                vect_h_q[i] <= '0;
            end
            en_q       <= '0;
            pend_q     <= '0;
            ins_q      <= '0;
            irq_prev_q <= '0;
            cur_q      <= '0;
            int_q      <= 1'b0;
            vect_q     <= '0;
            dout_q     <= '0;
`ifdef PIC_LEVEL_MODE_EN
            mode_q     <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (wr_hit && off == 8'(2 * i))     vect_l_q[i] <= din;
                if (wr_hit && off == 8'(2 * i + 1)) vect_h_q[i] <= din;
            end
            if (wr_hit && off == OFF_EN) en_q <= din[NUM_IRQ-1:0];
`ifdef PIC_LEVEL_MODE_EN
            if (wr_hit && off == OFF_MODE) mode_q <= din[NUM_IRQ-1:0];
`endif
            pend_q     <= pend_d;
            ins_q      <= ins_d;
            irq_prev_q <= irq;
            int_q      <= req;
            if (req) begin
                vect_q <= win_vec;
                cur_q  <= win_idx;
            end
            if (r_en) dout_q <= rdata;
        end
    end

    assign dout      = dout_q;
    assign interrupt = int_q;
    assign intVect   = vect_q;

endmodule

// File: tb/tb_pic_nest.sv
// Directed bench for pic_nest (NUM_IRQ=4, base 8'h00); level-mode scenario runs when PIC_LEVEL_MODE_EN is defined.
module tb_pic_nest;

    logic        clk;
    logic        reset;
    logic [7:0]  din;
    logic [7:0]  address;
    logic        w_en;
    logic        r_en;
    logic [7:0]  dout;
    logic        interrupt;
    logic [15:0] intVect;
    logic        intAck;
    logic [3:0]  irq;

    int checks;
    int errors;

    localparam logic [7:0] A_EN   = 8'd8;
    localparam logic [7:0] A_PEND = 8'd9;
    localparam logic [7:0] A_INS  = 8'd10;
    localparam logic [7:0] A_EOI  = 8'd11;
    localparam logic [7:0] A_MODE = 8'd12;

    pic_nest #(.PIC_ADDRESS(8'h00), .NUM_IRQ(4)) dut (
        .clk(clk), .reset(reset), .din(din), .address(address),
        .w_en(w_en), .r_en(r_en), .dout(dout), .interrupt(interrupt),
        .intVect(intVect), .intAck(intAck), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a; din = d; w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        address = a; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        d = dout;
    endtask

    task automatic pulse(input int unsigned k);
        irq[k] = 1'b1;
        tick();
        irq[k] = 1'b0;
    endtask

    task automatic ack_once();
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b0; din = '0; address = '0; w_en = 1'b0; r_en = 1'b0;
        intAck = 1'b0; irq = '0;
        #22;
        checks++;
        if (interrupt !== 1'b0 || intVect !== 16'h0000 || dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs int=%b vect=%h dout=%h want 0/0000/00", interrupt, intVect, dout);
        end
        reset = 1'b1;
        tick();
        for (int unsigned a = 0; a < 13; a++) begin
            rd(8'(a), d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_read off=%0d got=%h want=00", a, d);
            end
        end
        rd(8'hFF, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_read got=%h want=00", d);
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        wr(8'd4, 8'h34);
        wr(8'd5, 8'h12);
        wr(A_EN, 8'h04);
        pulse(2);
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL single_latency1 int=%b want=0", interrupt);
        end
        tick();
        checks++;
        if (interrupt !== 1'b1 || intVect !== 16'h1234) begin
            errors++;
            $display("FAIL single_req int=%b vect=%h want 1/1234", interrupt, intVect);
        end
        ack_once();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL single_ack_drop int=%b want=0", interrupt);
        end
        rd(A_PEND, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL single_pend got=%h want=00", d);
        end
        rd(A_INS, d);
        checks++;
        if (d !== 8'h04) begin
            errors++;
            $display("FAIL single_ins got=%h want=04", d);
        end
    endtask

    task automatic test_nest();
        logic [7:0] d;
        wr(A_EN, 8'h0D);
        wr(8'd0, 8'h00);
        wr(8'd1, 8'h01);
        wr(8'd6, 8'h33);
        wr(8'd7, 8'h33);
        pulse(3);
        tick();
        tick();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL nest_lower_blocked int=%b want=0", interrupt);
        end
        pulse(0);
        tick();
        checks++;
        if (interrupt !== 1'b1 || intVect !== 16'h0100) begin
            errors++;
            $display("FAIL nest_preempt int=%b vect=%h want 1/0100", interrupt, intVect);
        end
        ack_once();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL nest_ack_drop int=%b want=0", interrupt);
        end
        rd(A_INS, d);
        checks++;
        if (d !== 8'h05) begin
            errors++;
            $display("FAIL nest_ins_both got=%h want=05", d);
        end
        wr(A_EOI, 8'h00);
        rd(A_INS, d);
        checks++;
        if (d !== 8'h04 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL nest_eoi1 ins=%h int=%b want 04/0", d, interrupt);
        end
        wr(A_EOI, 8'h00);
        rd(A_INS, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL nest_eoi2 ins=%h want=00", d);
        end
        checks++;
        if (interrupt !== 1'b1 || intVect !== 16'h3333) begin
            errors++;
            $display("FAIL nest_ch3_presented int=%b vect=%h want 1/3333", interrupt, intVect);
        end
        rd(A_EOI, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL eoi_reads_zero got=%h want=00", d);
        end
        ack_once();
        wr(A_EOI, 8'h00);
    endtask

    task automatic test_mask_w1c();
        logic [7:0] d;
        wr(A_EN, 8'h00);
        pulse(1);
        tick();
        rd(A_PEND, d);
        checks++;
        if (d !== 8'h02 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL mask_pend pend=%h int=%b want 02/0", d, interrupt);
        end
        address = A_INS;
        tick();
        checks++;
        if (dout !== 8'h02) begin
            errors++;
            $display("FAIL dout_hold got=%h want=02", dout);
        end
        wr(A_PEND, 8'h02);
        rd(A_PEND, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL w1c_clear got=%h want=00", d);
        end
        wr(A_EN, 8'hF2);
        rd(A_EN, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("FAIL en_upper_bits got=%h want=02", d);
        end
        tick();
        tick();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL mask_no_req int=%b want=0", interrupt);
        end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        wr(8'd2, 8'hCD);
        wr(8'd3, 8'hAB);
        pulse(1);
        tick();
        checks++;
        if (interrupt !== 1'b1 || intVect !== 16'hABCD) begin
            errors++;
            $display("FAIL coll_req int=%b vect=%h want 1/abcd", interrupt, intVect);
        end
        irq[1] = 1'b1;
        intAck = 1'b1;
        tick();
        irq[1] = 1'b0;
        intAck = 1'b0;
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL coll_drop int=%b want=0", interrupt);
        end
        rd(A_PEND, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("FAIL coll_pend got=%h want=02", d);
        end
        rd(A_INS, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("FAIL coll_ins got=%h want=02", d);
        end
        wr(A_EOI, 8'h00);
        tick();
        checks++;
        if (interrupt !== 1'b1 || intVect !== 16'hABCD) begin
            errors++;
            $display("FAIL coll_represent int=%b vect=%h want 1/abcd", interrupt, intVect);
        end
        ack_once();
        wr(A_EOI, 8'h00);
    endtask

`ifdef PIC_LEVEL_MODE_EN
    task automatic test_level();
        logic [7:0] d;
        wr(A_MODE, 8'h01);
        rd(A_MODE, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL mode_read got=%h want=01", d);
        end
        wr(A_EN, 8'h01);
        irq[0] = 1'b1;
        tick();
        tick();
        checks++;
        if (interrupt !== 1'b1 || intVect !== 16'h0100) begin
            errors++;
            $display("FAIL level_req int=%b vect=%h want 1/0100", interrupt, intVect);
        end
        ack_once();
        tick();
        tick();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("FAIL level_no_reentry int=%b want=0", interrupt);
        end
        rd(A_PEND, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL level_pend_held got=%h want=01", d);
        end
        wr(A_EOI, 8'h00);
        tick();
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL level_rereq int=%b want=1", interrupt);
        end
        irq[0] = 1'b0;
        tick();
        rd(A_PEND, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL level_pend_drop got=%h want=00", d);
        end
        wr(A_MODE, 8'h00);
    endtask
`endif

    task automatic test_async_reset();
        logic [7:0] d;
        wr(A_EN, 8'h02);
        pulse(1);
        tick();
        checks++;
        if (interrupt !== 1'b1) begin
            errors++;
            $display("FAIL ares_setup int=%b want=1", interrupt);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (interrupt !== 1'b0 || intVect !== 16'h0000) begin
            errors++;
            $display("FAIL ares_async int=%b vect=%h want 0/0000", interrupt, intVect);
        end
        tick();
        reset = 1'b1;
        rd(A_EN, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL ares_en got=%h want=00", d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_nest();
        test_mask_w1c();
        test_collision();
`ifdef PIC_LEVEL_MODE_EN
        test_level();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
